ula_scheduler: RTL and testbench

//   Sequences the ULA image engines (direct copy, scaling algorithms) that share one ROM read port and one RAM write port.

---
 rtl/ula_sched_pkg.sv | 28 ++
 rtl/ula_port_mux.sv | 40 ++++
 rtl/ula_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_ula_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_sched_pkg.sv
// Shared types and constants for the ULA engine scheduler.
// Holds the FSM state encoding, the error codes reported to the HPS
// register bank and the opcode assignments of the image engines.
package ula_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH,
    ABORT
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_OP   = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  localparam int OP_COPY    = 0;
  localparam int OP_NN_ZOOM = 1;
  localparam int OP_REPL    = 2;
  localparam int OP_AVG     = 3;

  // Width of an index selecting one of n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ula_port_mux.sv
// N-to-1 selector placing one engine onto the shared ROM/RAM ports.
// Purely combinational so the selected engine sees its ROM exactly as
// with a direct connection; when en is low every shared output is 0.
module ula_port_mux
  import ula_sched_pkg::*;
#(
  parameter int N_ENG  = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_width(N_ENG)
) (
  input  logic                    en,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_ENG*ADDR_W-1:0] eng_rom_addr,
  input  logic [N_ENG*ADDR_W-1:0] eng_ram_wraddr,
  input  logic [N_ENG*DATA_W-1:0] eng_ram_data,
  input  logic [N_ENG-1:0]        eng_ram_wren,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic [ADDR_W-1:0]       ram_wraddr,
  output logic [DATA_W-1:0]       ram_data,
  output logic                    ram_wren
);

  // Route the selected engine's bus slices, or drive zeros when gated off.
  always_comb begin
    rom_addr   = '0;
    ram_wraddr = '0;
    ram_data   = '0;
    ram_wren   = 1'b0;
    for (int i = 0; i < N_ENG; i++) begin
      if (en && (sel == SEL_W'(i))) begin
        rom_addr   = eng_rom_addr[i*ADDR_W +: ADDR_W];
        ram_wraddr = eng_ram_wraddr[i*ADDR_W +: ADDR_W];
        ram_data   = eng_ram_data[i*DATA_W +: DATA_W];
        ram_wren   = eng_ram_wren[i];
      end
    end
  end

endmodule

// File: rtl/ula_scheduler.sv
// Scheduler for the ULA image engines sharing one ROM read port and one
// RAM write port. Accepts a command, holds the chosen engine in reset for
// CLR_CYC cycles, runs it with the shared ports muxed onto it, then parks
// it again and reports done or an error code.
// Optional: define ULA_SCHED_WRCOUNT_EN to count RAM write beats per run
// on wr_count; otherwise wr_count is tied to 0.
module ula_scheduler
  import ula_sched_pkg::*;
#(
  parameter int N_ENG   = 4,
  parameter int OP_W    = 3,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 1048576
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic [OP_W-1:0]         cmd_op,
  output logic                    cmd_ready,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              error,
  output logic [N_ENG-1:0]        eng_rst_n,
  input  logic [N_ENG-1:0]        eng_done,
  input  logic [N_ENG*ADDR_W-1:0] eng_rom_addr,
  input  logic [N_ENG*ADDR_W-1:0] eng_ram_wraddr,
  input  logic [N_ENG*DATA_W-1:0] eng_ram_data,
  input  logic [N_ENG-1:0]        eng_ram_wren,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic [ADDR_W-1:0]       ram_wraddr,
  output logic [DATA_W-1:0]       ram_data,
  output logic                    ram_wren,
  output logic [ADDR_W-1:0]       wr_count
);

  localparam int SEL_W  = sel_width(N_ENG);
  localparam int CLR_W  = $clog2(CLR_CYC + 1);
  localparam int TOUT_W = $clog2(TIMEOUT + 1);

  localparam logic [CLR_W-1:0]  CLR_LOAD  = CLR_W'(CLR_CYC);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);
  localparam logic [OP_W:0]     OP_LIMIT  = (OP_W + 1)'(N_ENG);

  state_t            state;
  state_t            state_nxt;
  logic [SEL_W-1:0]  sel;
  logic [CLR_W-1:0]  clr_cnt;
  logic [TOUT_W-1:0] tout_cnt;
  logic              accept;
  logic              op_ok;
  logic              mux_en;
  logic              sel_done;
  logic [N_ENG-1:0]  sel_mask;

  assign accept = cmd_valid && cmd_ready;
  assign op_ok  = ({1'b0, cmd_op} < OP_LIMIT);

  // One-hot mask of the selected engine and its done flag.
  always_comb begin
    sel_mask = '0;
    sel_done = 1'b0;
    for (int i = 0; i < N_ENG; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_mask[i] = 1'b1;
        sel_done    = eng_done[i];
      end
    end
  end

  // State register; reset abandons any run and returns to IDLE at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs; engines stay in reset except during RUN.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mux_en    = 1'b0;
    eng_rst_n = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && op_ok) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (clr_cnt <= CLR_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        mux_en    = 1'b1;
        eng_rst_n = sel_mask;
        if (sel_done) begin
          state_nxt = FLUSH;
        end else if (tout_cnt == TOUT_LAST) begin
          state_nxt = ABORT;
        end
      end
      FLUSH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ABORT: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the engine select only when a legal command is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel <= '0;
    end else if (accept && op_ok) begin
      sel <= SEL_W'(cmd_op);
    end
  end

  // Sticky error: cleared by a good command, set by a bad opcode or timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= ERR_OK;
    end else if (accept) begin
      error <= op_ok ? ERR_OK : ERR_OP;
    end else if (state == RUN && state_nxt == ABORT) begin
      error <= ERR_TOUT;
    end
  end

  // Count the engine's reset hold time down, stopping at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt <= '0;
    end else if (accept && op_ok) begin
      clr_cnt <= CLR_LOAD;
    end else if (state == CLEAR && clr_cnt > CLR_LAST) begin
      clr_cnt <= clr_cnt - 1'b1;
    end
  end

  // Timeout counter: zeroed on entry to RUN, saturates at the abort point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tout_cnt <= '0;
    end else if (state == CLEAR && state_nxt == RUN) begin
      tout_cnt <= '0;
    end else if (state == RUN && state_nxt == RUN && tout_cnt < TOUT_LAST) begin
      tout_cnt <= tout_cnt + 1'b1;
    end
  end

  ula_port_mux #(
    .N_ENG (N_ENG),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .SEL_W (SEL_W)
  ) u_port_mux (
    .en            (mux_en),
    .sel           (sel),
    .eng_rom_addr  (eng_rom_addr),
    .eng_ram_wraddr(eng_ram_wraddr),
    .eng_ram_data  (eng_ram_data),
    .eng_ram_wren  (eng_ram_wren),
    .rom_addr      (rom_addr),
    .ram_wraddr    (ram_wraddr),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren)
  );

`ifdef ULA_SCHED_WRCOUNT_EN
  // Count RAM write beats of the current run, holding after it ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count <= '0;
    end else if (accept) begin
      wr_count <= '0;
    end else if (state == RUN && ram_wren && wr_count != '1) begin
      wr_count <= wr_count + 1'b1;
    end
  end
`else
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_ula_scheduler.sv
// Bench for ula_scheduler with four behavioural stub engines. Each engine
// writes n_pix[i] pixels copied from a ROM function, then raises done;
// parked engines drive junk and a spurious write enable onto their buses.
module tb_ula_scheduler;

  localparam int N_ENG   = 4;
  localparam int OP_W    = 3;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 8;
  localparam int CLR_CYC = 2;
  localparam int TIMEOUT = 64;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    cmd_valid;
  logic [OP_W-1:0]         cmd_op;
  logic                    cmd_ready;
  logic                    busy;
  logic                    done;
  logic [1:0]              error;
  logic [N_ENG-1:0]        eng_rst_n;
  logic [N_ENG-1:0]        eng_done;
  logic [N_ENG*ADDR_W-1:0] eng_rom_addr;
  logic [N_ENG*ADDR_W-1:0] eng_ram_wraddr;
  logic [N_ENG*DATA_W-1:0] eng_ram_data;
  logic [N_ENG-1:0]        eng_ram_wren;
  logic [ADDR_W-1:0]       rom_addr;
  logic [ADDR_W-1:0]       ram_wraddr;
  logic [DATA_W-1:0]       ram_data;
  logic                    ram_wren;
  logic [ADDR_W-1:0]       wr_count;

  int checks = 0;
  int errors = 0;
  int n_pix[N_ENG];

  logic [DATA_W-1:0] ram[int];
  int wr_seen;
  int outside_bad;

  always #5 clk = ~clk;

  ula_scheduler #(
    .N_ENG(N_ENG), .OP_W(OP_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .CLR_CYC(CLR_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .busy(busy), .done(done), .error(error),
    .eng_rst_n(eng_rst_n), .eng_done(eng_done), .eng_rom_addr(eng_rom_addr),
    .eng_ram_wraddr(eng_ram_wraddr), .eng_ram_data(eng_ram_data),
    .eng_ram_wren(eng_ram_wren), .rom_addr(rom_addr), .ram_wraddr(ram_wraddr),
    .ram_data(ram_data), .ram_wren(ram_wren), .wr_count(wr_count)
  );

  // Image ROM contents as a function of address.
  function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'd7 + 8'd3;
    return t ^ a[10:3];
  endfunction

  // Stub copy engines; the running engine reads the ROM through the shared port.
  for (genvar g = 0; g < N_ENG; g++) begin : gen_eng
    int cnt;
    always @(posedge clk) begin
      if (!eng_rst_n[g]) cnt <= 0;
      else if (cnt < n_pix[g]) cnt <= cnt + 1;
    end
    assign eng_rom_addr[g*ADDR_W +: ADDR_W]   = eng_rst_n[g] ? ADDR_W'(cnt) : ADDR_W'(32'h7ABC0 + g);
    assign eng_ram_wraddr[g*ADDR_W +: ADDR_W] = eng_rst_n[g] ? ADDR_W'(cnt) : ADDR_W'(32'h7ABC0 + g);
    assign eng_ram_data[g*DATA_W +: DATA_W]   = eng_rst_n[g] ? rom_val(rom_addr) : 8'hEE;
    assign eng_ram_wren[g] = eng_rst_n[g] ? (cnt < n_pix[g]) : 1'b1;
    assign eng_done[g]     = eng_rst_n[g] && (cnt >= n_pix[g]);
  end

  // Frame-buffer RAM model.
  always @(posedge clk) begin
    if (ram_wren) begin
      ram[int'(ram_wraddr)] = ram_data;
      wr_seen++;
    end
  end

  // No engine running means the shared ports must all be quiet.
  always @(negedge clk) begin
    if (eng_rst_n == '0 && (rom_addr != '0 || ram_wraddr != '0 || ram_data != '0 || ram_wren))
      outside_bad++;
  end

  // Issue one command and follow it until the scheduler goes idle again.
  task automatic do_run(input logic [OP_W-1:0] op, output int busy_cyc, output int run_cyc,
                        output int other_rel, output int done_cnt, output logic [1:0] err_first,
                        output logic [1:0] err_end, output bit timed_out);
    logic [N_ENG-1:0] mask;
    int guard;
    mask = '0;
    mask[op] = 1'b1;
    ram.delete();
    wr_seen = 0;
    busy_cyc = 0; run_cyc = 0; other_rel = 0; done_cnt = 0; guard = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = OP_W'($urandom);
    err_first = error;
    while (busy && guard < 400) begin
      busy_cyc++;
      if ((eng_rst_n & mask) != '0) run_cyc++;
      if ((eng_rst_n & ~mask) != '0) other_rel++;
      if (done) done_cnt++;
      @(negedge clk);
      guard++;
    end
    timed_out = (guard >= 400);
    err_end = error;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, eng_rst_n, rom_addr, ram_wraddr, ram_data, ram_wren, wr_count} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%0b done=%0b error=%0b eng_rst_n=%b rom=%0h wren=%0b wr_count=%0d, required all 0",
               busy, done, error, eng_rst_n, rom_addr, ram_wren, wr_count);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: cmd_ready=%0b, required 1", cmd_ready);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error, eng_rst_n} !== '0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%0b done=%0b error=%0b eng_rst_n=%b, required 0",
               busy, done, error, eng_rst_n);
    end
  endtask

  // Random and boundary pixel counts on every engine, compared with the timing rules.
  task automatic test_runs();
    int ops[8];
    int ns[8];
    int busy_cyc, run_cyc, other_rel, done_cnt, bad, bad0, exp_run, exp_wr, exp_wc;
    bit exp_done, timed_out;
    logic [1:0] err_first, err_end, exp_err;
    ops = '{0, 1, 2, 3, 2, 3, 0, 1};
    ns  = '{$urandom_range(1, 62), $urandom_range(1, 62), $urandom_range(1, 62),
            $urandom_range(1, 62), TIMEOUT - 1, TIMEOUT, $urandom_range(65, 200), 1};
    for (int t = 0; t < 8; t++) begin
      for (int e = 0; e < N_ENG; e++) n_pix[e] = $urandom_range(1, 40);
      n_pix[ops[t]] = ns[t];
      exp_done = (ns[t] < TIMEOUT);
      exp_run  = exp_done ? ns[t] + 1 : TIMEOUT;
      exp_wr   = (ns[t] < TIMEOUT) ? ns[t] : TIMEOUT;
      exp_err  = exp_done ? 2'b00 : 2'b10;
`ifdef ULA_SCHED_WRCOUNT_EN
      exp_wc = exp_wr;
`else
      exp_wc = 0;
`endif
      bad0 = outside_bad;
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL run%0d_ready: cmd_ready=%0b, required 1", t, cmd_ready);
      end
      do_run(OP_W'(ops[t]), busy_cyc, run_cyc, other_rel, done_cnt, err_first, err_end, timed_out);
      checks++;
      if (timed_out) begin
        errors++;
        $display("[TB] FAIL run%0d_finish: scheduler still busy after 400 cycles, required idle", t);
      end
      checks++;
      if (busy_cyc != CLR_CYC + exp_run + 1) begin
        errors++;
        $display("[TB] FAIL run%0d_busy_cycles: got %0d, required %0d (n=%0d)", t, busy_cyc, CLR_CYC + exp_run + 1, ns[t]);
      end
      checks++;
      if (run_cyc != exp_run) begin
        errors++;
        $display("[TB] FAIL run%0d_run_cycles: got %0d, required %0d (n=%0d)", t, run_cyc, exp_run, ns[t]);
      end
      checks++;
      if (other_rel != 0) begin
        errors++;
        $display("[TB] FAIL run%0d_other_engines: released %0d cycles, required 0", t, other_rel);
      end
      checks++;
      if (done_cnt != int'(exp_done)) begin
        errors++;
        $display("[TB] FAIL run%0d_done_pulses: got %0d, required %0d (n=%0d)", t, done_cnt, exp_done, ns[t]);
      end
      checks++;
      if (err_first !== 2'b00 || err_end !== exp_err) begin
        errors++;
        $display("[TB] FAIL run%0d_error: start=%b end=%b, required 00 and %b", t, err_first, err_end, exp_err);
      end
      checks++;
      if (wr_seen != exp_wr || ram.num() != exp_wr) begin
        errors++;
        $display("[TB] FAIL run%0d_writes: beats=%0d addrs=%0d, required %0d", t, wr_seen, ram.num(), exp_wr);
      end
      bad = 0;
      for (int k = 0; k < exp_wr; k++)
        if (!ram.exists(k) || ram[k] !== rom_val(ADDR_W'(k))) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("[TB] FAIL run%0d_ram_copy: %0d pixels differ from ROM, required 0", t, bad);
      end
      checks++;
      if (outside_bad != bad0) begin
        errors++;
        $display("[TB] FAIL run%0d_quiet_ports: %0d active cycles outside RUN, required 0", t, outside_bad - bad0);
      end
      checks++;
      if (int'(wr_count) != exp_wc) begin
        errors++;
        $display("[TB] FAIL run%0d_wr_count: got %0d, required %0d", t, wr_count, exp_wc);
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || eng_rst_n !== '0) begin
        errors++;
        $display("[TB] FAIL run%0d_idle: done=%0b busy=%0b eng_rst_n=%b, required 0", t, done, busy, eng_rst_n);
      end
    end
  endtask

  // Illegal opcodes flag an error without touching the engines; a good command clears it.
  task automatic test_bad_op();
    int busy_cyc, run_cyc, other_rel, done_cnt;
    bit timed_out;
    logic [1:0] err_first, err_end;
    logic [OP_W-1:0] op;
    for (int t = 0; t < 2; t++) begin
      op = OP_W'($urandom_range(N_ENG, (1 << OP_W) - 1));
      cmd_valid = 1'b1;
      cmd_op = op;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (error !== 2'b01 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bad_op%0d_status: error=%b done=%0b busy=%0b ready=%0b, required 01/0/0/1",
                 op, error, done, busy, cmd_ready);
      end
      repeat (3) begin
        checks++;
        if (eng_rst_n !== '0) begin
          errors++;
          $display("[TB] FAIL bad_op%0d_engines: eng_rst_n=%b, required 0", op, eng_rst_n);
        end
        @(negedge clk);
      end
    end
    n_pix[1] = $urandom_range(5, 30);
    do_run(OP_W'(1), busy_cyc, run_cyc, other_rel, done_cnt, err_first, err_end, timed_out);
    checks++;
    if (err_first !== 2'b00 || err_end !== 2'b00 || done_cnt != 1 || timed_out) begin
      errors++;
      $display("[TB] FAIL bad_op_recover: error start=%b end=%b done=%0d, required 00/00/1", err_first, err_end, done_cnt);
    end
  endtask

  // A command held during a run is ignored, then accepted on the first idle cycle.
  task automatic test_back_to_back();
    int rel1, rel2_first, rel2_second, dn, guard;
    logic busy_after;
    n_pix[1] = 20;
    n_pix[2] = 10;
    rel1 = 0; rel2_first = 0; rel2_second = 0; dn = 0; guard = 0;
    cmd_valid = 1'b1;
    cmd_op = OP_W'(1);
    @(negedge clk);
    cmd_op = OP_W'(2);
    while (busy && guard < 400) begin
      if (eng_rst_n[1]) rel1++;
      if (eng_rst_n[2]) rel2_first++;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cmd_ready !== 1'b1 || guard >= 400) begin
      errors++;
      $display("[TB] FAIL b2b_idle: cmd_ready=%0b guard=%0d, required 1 within 400", cmd_ready, guard);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    busy_after = busy;
    guard = 0;
    while (busy && guard < 400) begin
      if (eng_rst_n[2]) rel2_second++;
      if (done) dn++;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (rel1 != 21 || rel2_first != 0) begin
      errors++;
      $display("[TB] FAIL b2b_first_run: eng1 run=%0d eng2 run=%0d, required 21 and 0", rel1, rel2_first);
    end
    checks++;
    if (busy_after !== 1'b1 || rel2_second != 11 || dn != 1) begin
      errors++;
      $display("[TB] FAIL b2b_second_run: busy=%0b eng2 run=%0d done=%0d, required 1/11/1", busy_after, rel2_second, dn);
    end
  endtask

  // Reset pulled mid-run clears everything immediately; a later run works.
  task automatic test_reset_mid_run();
    int guard, dn, busy_cyc, run_cyc, other_rel, done_cnt;
    bit timed_out;
    logic [1:0] err_first, err_end;
    n_pix[0] = 50;
    guard = 0;
    cmd_valid = 1'b1;
    cmd_op = OP_W'(0);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!eng_rst_n[0] && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, eng_rst_n, rom_addr, ram_wraddr, ram_data, ram_wren, wr_count} !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: busy=%0b done=%0b eng_rst_n=%b rom=%0h wren=%0b wr_count=%0d, required all 0",
               busy, done, eng_rst_n, rom_addr, ram_wren, wr_count);
    end
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || eng_rst_n != '0) dn++;
    end
    checks++;
    if (dn != 0 || guard >= 10) begin
      errors++;
      $display("[TB] FAIL midrun_held: %0d active cycles (guard %0d), required 0", dn, guard);
    end
    reset = 1'b1;
    @(negedge clk);
    n_pix[0] = 30;
    do_run(OP_W'(0), busy_cyc, run_cyc, other_rel, done_cnt, err_first, err_end, timed_out);
    checks++;
    if (done_cnt != 1 || run_cyc != 31 || err_end !== 2'b00 || wr_seen != 30 || timed_out) begin
      errors++;
      $display("[TB] FAIL midrun_recover: done=%0d run=%0d error=%b writes=%0d, required 1/31/00/30",
               done_cnt, run_cyc, err_end, wr_seen);
    end
  endtask

  initial begin
    outside_bad = 0;
    wr_seen = 0;
    for (int e = 0; e < N_ENG; e++) n_pix[e] = 8;
    test_reset();
    test_runs();
    test_bad_op();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] time limit");
  end

endmodule
